// File: rtl/decode_pkg.sv
// Shared definitions for the RV32I decode stage: opcode constants, the
// unified ALU-op encoding, immediate formats, the control bundle and the
// immediate-assembly helper.
package decode_pkg;

  // RV32I major opcodes handled by the decoder
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Unified ALU op: I-type variants reuse the R-type code
  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_XOR   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_AND   = 4'd4,
    ALU_SLL   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5,
    IMM_SH   = 3'd6
  } imm_fmt_e;

  typedef struct packed {
    alu_op_e    alu_op;
    logic       alu_src;
    logic       alu_a_pc;
    logic       sftmd;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic [2:0] br_funct3;
    logic       jal;
    logic       jalr;
    logic       illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // Assemble the 32-bit sign-extended immediate for a given format
  function automatic logic [31:0] imm32(input logic [31:0] instr, input imm_fmt_e fmt);
    logic [31:0] r;
    case (fmt)
      IMM_I:   r = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   r = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   r = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   r = {instr[31:12], 12'h000};
      IMM_J:   r = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_SH:  r = {27'h0000000, instr[24:20]};
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/decode_comb.sv
// Pure combinational RV32I decoder.
// Ports:
//   instr_i      - instruction word
//   ctrl_o       - control bundle (all-zero except illegal when undecodable)
//   imm_o        - sign-extended immediate (XLEN bits)
//   rs1_o/rs2_o/rd_o - raw register index fields
//   uses_rs1_o/uses_rs2_o - instruction reads rs1 / rs2 (for interlock)
module decode_comb
  import decode_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit EN_SLT   = 1'b1,
  parameter bit EN_UPPER = 1'b1
) (
  input  logic [31:0]     instr_i,
  output ctrl_t           ctrl_o,
  output logic [XLEN-1:0] imm_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [4:0]      rd_o,
  output logic            uses_rs1_o,
  output logic            uses_rs2_o
);

  logic [6:0] opcode_s;
  logic [2:0] funct3_s;
  logic [6:0] funct7_s;
  ctrl_t      ctrl_s;
  imm_fmt_e   fmt_s;
  logic       ill_s;
  logic [31:0] imm32_s;

  assign opcode_s = instr_i[6:0];
  assign funct3_s = instr_i[14:12];
  assign funct7_s = instr_i[31:25];
  assign rs1_o    = instr_i[19:15];
  assign rs2_o    = instr_i[24:20];
  assign rd_o     = instr_i[11:7];

  assign imm32_s = imm32(instr_i, fmt_s);
  assign imm_o   = XLEN'($signed(imm32_s));

  // Opcode/funct decode into control bundle and legality
  always_comb begin
    ctrl_s     = CTRL_NOP;
    fmt_s      = IMM_NONE;
    ill_s      = 1'b0;
    uses_rs1_o = 1'b0;
    uses_rs2_o = 1'b0;
    case (opcode_s)
      OPC_OP: begin
        uses_rs1_o       = 1'b1;
        uses_rs2_o       = 1'b1;
        ctrl_s.reg_write = 1'b1;
        case ({funct7_s, funct3_s})
          {F7_BASE, 3'b000}: ctrl_s.alu_op = ALU_ADD;
          {F7_ALT,  3'b000}: ctrl_s.alu_op = ALU_SUB;
          {F7_BASE, 3'b001}: begin ctrl_s.alu_op = ALU_SLL; ctrl_s.sftmd = 1'b1; end
          {F7_BASE, 3'b010}: begin ctrl_s.alu_op = ALU_SLT;  ill_s = ~EN_SLT; end
          {F7_BASE, 3'b011}: begin ctrl_s.alu_op = ALU_SLTU; ill_s = ~EN_SLT; end
          {F7_BASE, 3'b100}: ctrl_s.alu_op = ALU_XOR;
          {F7_BASE, 3'b101}: begin ctrl_s.alu_op = ALU_SRL; ctrl_s.sftmd = 1'b1; end
          {F7_ALT,  3'b101}: begin ctrl_s.alu_op = ALU_SRA; ctrl_s.sftmd = 1'b1; end
          {F7_BASE, 3'b110}: ctrl_s.alu_op = ALU_OR;
          {F7_BASE, 3'b111}: ctrl_s.alu_op = ALU_AND;
          default:           ill_s = 1'b1;
        endcase
      end
      OPC_OPIMM: begin
        uses_rs1_o       = 1'b1;
        ctrl_s.reg_write = 1'b1;
        ctrl_s.alu_src   = 1'b1;
        fmt_s            = IMM_I;
        case (funct3_s)
          3'b000: ctrl_s.alu_op = ALU_ADD;
          3'b010: begin ctrl_s.alu_op = ALU_SLT;  ill_s = ~EN_SLT; end
          3'b011: begin ctrl_s.alu_op = ALU_SLTU; ill_s = ~EN_SLT; end
          3'b100: ctrl_s.alu_op = ALU_XOR;
          3'b110: ctrl_s.alu_op = ALU_OR;
          3'b111: ctrl_s.alu_op = ALU_AND;
          3'b001: begin
            // Shift immediates carry funct7 in the upper imm bits
            fmt_s         = IMM_SH;
            ctrl_s.sftmd  = 1'b1;
            ctrl_s.alu_op = ALU_SLL;
            ill_s         = (funct7_s != F7_BASE);
          end
          3'b101: begin
            fmt_s        = IMM_SH;
            ctrl_s.sftmd = 1'b1;
            if (funct7_s == F7_BASE) begin
              ctrl_s.alu_op = ALU_SRL;
            end else if (funct7_s == F7_ALT) begin
              ctrl_s.alu_op = ALU_SRA;
            end else begin
              ill_s = 1'b1;
            end
          end
          default: ill_s = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        uses_rs1_o        = 1'b1;
        fmt_s             = IMM_I;
        ctrl_s.alu_op     = ALU_ADD;
        ctrl_s.alu_src    = 1'b1;
        ctrl_s.mem_read   = 1'b1;
        ctrl_s.mem_to_reg = 1'b1;
        ctrl_s.reg_write  = 1'b1;
        case (funct3_s)
          3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ill_s = 1'b0;
          default:                                ill_s = 1'b1;
        endcase
      end
      OPC_STORE: begin
        uses_rs1_o       = 1'b1;
        uses_rs2_o       = 1'b1;
        fmt_s            = IMM_S;
        ctrl_s.alu_op    = ALU_ADD;
        ctrl_s.alu_src   = 1'b1;
        ctrl_s.mem_write = 1'b1;
        case (funct3_s)
          3'b000, 3'b001, 3'b010: ill_s = 1'b0;
          default:                ill_s = 1'b1;
        endcase
      end
      OPC_BRANCH: begin
        uses_rs1_o       = 1'b1;
        uses_rs2_o       = 1'b1;
        fmt_s            = IMM_B;
        ctrl_s.alu_op    = ALU_SUB;
        ctrl_s.branch    = 1'b1;
        ctrl_s.br_funct3 = funct3_s;
        case (funct3_s)
          3'b010, 3'b011: ill_s = 1'b1;
          default:        ill_s = 1'b0;
        endcase
      end
      OPC_JAL: begin
        fmt_s            = IMM_J;
        ctrl_s.jal       = 1'b1;
        ctrl_s.reg_write = 1'b1;
      end
      OPC_JALR: begin
        uses_rs1_o       = 1'b1;
        fmt_s            = IMM_I;
        ctrl_s.alu_op    = ALU_ADD;
        ctrl_s.alu_src   = 1'b1;
        ctrl_s.jalr      = 1'b1;
        ctrl_s.reg_write = 1'b1;
        ill_s            = (funct3_s != 3'b000);
      end
      OPC_LUI: begin
        fmt_s            = IMM_U;
        ctrl_s.alu_op    = ALU_PASSB;
        ctrl_s.alu_src   = 1'b1;
        ctrl_s.reg_write = 1'b1;
        ill_s            = ~EN_UPPER;
      end
      OPC_AUIPC: begin
        fmt_s            = IMM_U;
        ctrl_s.alu_op    = ALU_ADD;
        ctrl_s.alu_src   = 1'b1;
        ctrl_s.alu_a_pc  = 1'b1;
        ctrl_s.reg_write = 1'b1;
        ill_s            = ~EN_UPPER;
      end
      default: ill_s = 1'b1;
    endcase
  end

  // Final bundle: x0 is never written; illegal kills every side effect
  always_comb begin
    ctrl_o = ctrl_s;
    if (ill_s) begin
      ctrl_o         = CTRL_NOP;
      ctrl_o.illegal = 1'b1;
    end else if (rd_o == 5'd0) begin
      ctrl_o.reg_write = 1'b0;
    end else begin
      ctrl_o.illegal = 1'b0;
    end
  end

endmodule

// File: rtl/decode_pipe_stage.sv
// Registered RV32I decode stage with one-entry ID/EX register.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   in_valid/in_ready   - fetch handshake; in_instr/in_pc instruction and PC
//   flush               - discard held bundle and any incoming instruction
//   out_valid/out_ready - execute handshake
//   out_*               - registered PC, indices, immediate and control bundle
//   load_use_stall      - combinational load-use interlock indication
//   illegal_count       - saturating count of accepted illegal instructions
module decode_pipe_stage
  import decode_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit EN_SLT   = 1'b1,
  parameter bit EN_UPPER = 1'b1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic [XLEN-1:0]  out_imm,
  output logic [3:0]       out_alu_op,
  output logic             out_alu_src,
  output logic             out_alu_a_pc,
  output logic             out_sftmd,
  output logic             out_reg_write,
  output logic             out_mem_read,
  output logic             out_mem_write,
  output logic             out_mem_to_reg,
  output logic             out_branch,
  output logic [2:0]       out_br_funct3,
  output logic             out_jal,
  output logic             out_jalr,
  output logic             out_illegal,
  output logic             load_use_stall,
  output logic [CNT_W-1:0] illegal_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  ctrl_t           dec_ctrl_s;
  logic [XLEN-1:0] dec_imm_s;
  logic [4:0]      dec_rs1_s, dec_rs2_s, dec_rd_s;
  logic            uses_rs1_s, uses_rs2_s;
  logic            load_use_s, accept_s, clear_s;

  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, pc_d, imm_q, imm_d;
  logic [4:0]      rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  ctrl_t           ctrl_q, ctrl_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  decode_comb #(
    .XLEN     (XLEN),
    .EN_SLT   (EN_SLT),
    .EN_UPPER (EN_UPPER)
  ) u_decode_comb (
    .instr_i    (in_instr),
    .ctrl_o     (dec_ctrl_s),
    .imm_o      (dec_imm_s),
    .rs1_o      (dec_rs1_s),
    .rs2_o      (dec_rs2_s),
    .rd_o       (dec_rd_s),
    .uses_rs1_o (uses_rs1_s),
    .uses_rs2_o (uses_rs2_s)
  );

  // A held load whose destination the incoming instruction reads must
  // drain before that instruction can be decoded into the register.
  assign load_use_s = valid_q & ctrl_q.mem_read & (rd_q != 5'd0) & in_valid &
                      ((uses_rs1_s & (dec_rs1_s == rd_q)) |
                       (uses_rs2_s & (dec_rs2_s == rd_q)));
  assign in_ready   = (~valid_q | out_ready) & ~load_use_s & ~flush;
  assign accept_s   = in_valid & in_ready;

  // Next-state for the ID/EX register and the illegal counter
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    imm_d   = imm_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    ctrl_d  = ctrl_q;
    cnt_d   = cnt_q;
    clear_s = 1'b0;
    if (flush) begin
      clear_s = 1'b1;
    end else if (accept_s) begin
      valid_d = 1'b1;
      pc_d    = in_pc;
      imm_d   = dec_imm_s;
      rs1_d   = dec_rs1_s;
      rs2_d   = dec_rs2_s;
      rd_d    = dec_rd_s;
      ctrl_d  = dec_ctrl_s;
      if (dec_ctrl_s.illegal && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_W'(1'b1);
      end else begin
        cnt_d = cnt_q;
      end
    end else if (out_ready) begin
      clear_s = 1'b1;
    end else begin
      valid_d = valid_q;
    end
    // Bubbles carry an all-zero bundle so nothing downstream acts on stale fields
    if (clear_s) begin
      valid_d = 1'b0;
      pc_d    = '0;
      imm_d   = '0;
      rs1_d   = 5'd0;
      rs2_d   = 5'd0;
      rd_d    = 5'd0;
      ctrl_d  = CTRL_NOP;
    end else begin
      clear_s = 1'b0;
    end
  end

  // ID/EX register and counter state
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      imm_q   <= '0;
      rs1_q   <= 5'd0;
      rs2_q   <= 5'd0;
      rd_q    <= 5'd0;
      ctrl_q  <= CTRL_NOP;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      imm_q   <= imm_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      ctrl_q  <= ctrl_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid      = valid_q;
  assign out_pc         = pc_q;
  assign out_rs1        = rs1_q;
  assign out_rs2        = rs2_q;
  assign out_rd         = rd_q;
  assign out_imm        = imm_q;
  assign out_alu_op     = ctrl_q.alu_op;
  assign out_alu_src    = ctrl_q.alu_src;
  assign out_alu_a_pc   = ctrl_q.alu_a_pc;
  assign out_sftmd      = ctrl_q.sftmd;
  assign out_reg_write  = ctrl_q.reg_write;
  assign out_mem_read   = ctrl_q.mem_read;
  assign out_mem_write  = ctrl_q.mem_write;
  assign out_mem_to_reg = ctrl_q.mem_to_reg;
  assign out_branch     = ctrl_q.branch;
  assign out_br_funct3  = ctrl_q.br_funct3;
  assign out_jal        = ctrl_q.jal;
  assign out_jalr       = ctrl_q.jalr;
  assign out_illegal    = ctrl_q.illegal;
  assign load_use_stall = load_use_s;
  assign illegal_count  = cnt_q;

endmodule

// File: tb/tb_decode_pipe_stage.sv
// Directed self-checking bench. Two instances share stimulus: dut_a with
// default parameters, dut_b with SLT/upper-immediate ops disabled and a
// 2-bit illegal counter.
module tb_decode_pipe_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, flush, out_ready;
  logic [31:0] in_instr, in_pc;

  logic        a_in_ready, a_out_valid, a_alu_src, a_alu_a_pc, a_sftmd, a_reg_write;
  logic        a_mem_read, a_mem_write, a_mem_to_reg, a_branch, a_jal, a_jalr, a_illegal, a_lus;
  logic [31:0] a_pc, a_imm;
  logic [4:0]  a_rs1, a_rs2, a_rd;
  logic [3:0]  a_alu_op;
  logic [2:0]  a_bf3;
  logic [15:0] a_cnt;

  logic        b_in_ready, b_out_valid, b_alu_src, b_alu_a_pc, b_sftmd, b_reg_write;
  logic        b_mem_read, b_mem_write, b_mem_to_reg, b_branch, b_jal, b_jalr, b_illegal, b_lus;
  logic [31:0] b_pc, b_imm;
  logic [4:0]  b_rs1, b_rs2, b_rd;
  logic [3:0]  b_alu_op;
  logic [2:0]  b_bf3;
  logic [1:0]  b_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_pipe_stage dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_pc(a_pc), .out_rs1(a_rs1), .out_rs2(a_rs2), .out_rd(a_rd), .out_imm(a_imm),
    .out_alu_op(a_alu_op), .out_alu_src(a_alu_src), .out_alu_a_pc(a_alu_a_pc),
    .out_sftmd(a_sftmd), .out_reg_write(a_reg_write), .out_mem_read(a_mem_read),
    .out_mem_write(a_mem_write), .out_mem_to_reg(a_mem_to_reg), .out_branch(a_branch),
    .out_br_funct3(a_bf3), .out_jal(a_jal), .out_jalr(a_jalr), .out_illegal(a_illegal),
    .load_use_stall(a_lus), .illegal_count(a_cnt)
  );

  decode_pipe_stage #(.EN_SLT(1'b0), .EN_UPPER(1'b0), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_pc(b_pc), .out_rs1(b_rs1), .out_rs2(b_rs2), .out_rd(b_rd), .out_imm(b_imm),
    .out_alu_op(b_alu_op), .out_alu_src(b_alu_src), .out_alu_a_pc(b_alu_a_pc),
    .out_sftmd(b_sftmd), .out_reg_write(b_reg_write), .out_mem_read(b_mem_read),
    .out_mem_write(b_mem_write), .out_mem_to_reg(b_mem_to_reg), .out_branch(b_branch),
    .out_br_funct3(b_bf3), .out_jal(b_jal), .out_jalr(b_jalr), .out_illegal(b_illegal),
    .load_use_stall(b_lus), .illegal_count(b_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_instr = 32'h0000_0000; in_pc = 32'h0000_0000;
    tick(); tick();
    check_eq("rst_valid", {31'd0, a_out_valid}, 32'd0);
    check_eq("rst_imm", a_imm, 32'd0);
    check_eq("rst_rd", {27'd0, a_rd}, 32'd0);
    check_eq("rst_cnt", {16'd0, a_cnt}, 32'd0);
    rst = 1'b0;

    // addi x1,x0,5
    drive(32'h0050_0093, 32'h0000_0100);
    #1 check_eq("addi_in_ready", {31'd0, a_in_ready}, 32'd1);
    tick();
    check_eq("addi_valid", {31'd0, a_out_valid}, 32'd1);
    check_eq("addi_alu_op", {28'd0, a_alu_op}, 32'd0);
    check_eq("addi_alu_src", {31'd0, a_alu_src}, 32'd1);
    check_eq("addi_imm", a_imm, 32'd5);
    check_eq("addi_rd", {27'd0, a_rd}, 32'd1);
    check_eq("addi_rw", {31'd0, a_reg_write}, 32'd1);
    check_eq("addi_pc", a_pc, 32'h0000_0100);

    // lw x2,0(x1) then add x3,x2,x2 -> one bubble
    drive(32'h0000_A103, 32'h0000_0104);
    tick();
    check_eq("lw_mem_read", {31'd0, a_mem_read}, 32'd1);
    check_eq("lw_rd", {27'd0, a_rd}, 32'd2);
    drive(32'h0021_01B3, 32'h0000_0108);
    #1 check_eq("lu_stall", {31'd0, a_lus}, 32'd1);
    check_eq("lu_in_ready", {31'd0, a_in_ready}, 32'd0);
    tick();
    check_eq("lu_bubble", {31'd0, a_out_valid}, 32'd0);
    check_eq("lu_stall_clear", {31'd0, a_lus}, 32'd0);
    tick();
    check_eq("add_valid", {31'd0, a_out_valid}, 32'd1);
    check_eq("add_alu_op", {28'd0, a_alu_op}, 32'd0);
    check_eq("add_rw", {31'd0, a_reg_write}, 32'd1);
    check_eq("add_rd", {27'd0, a_rd}, 32'd3);
    check_eq("add_pc", a_pc, 32'h0000_0108);

    // ori x4,x0,7 accepted, then andi x5,x0,15 blocked by backpressure
    drive(32'h0070_6213, 32'h0000_010C);
    tick();
    check_eq("ori_alu_op", {28'd0, a_alu_op}, 32'd3);
    out_ready = 1'b0;
    drive(32'h00F0_7293, 32'h0000_0110);
    for (int i = 0; i < 3; i++) begin
      #1 check_eq("bp_in_ready", {31'd0, a_in_ready}, 32'd0);
      tick();
      check_eq("bp_hold_imm", a_imm, 32'd7);
      check_eq("bp_hold_valid", {31'd0, a_out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    #1 check_eq("bp_release_ready", {31'd0, a_in_ready}, 32'd1);
    tick();
    check_eq("andi_alu_op", {28'd0, a_alu_op}, 32'd4);
    check_eq("andi_imm", a_imm, 32'd15);
    check_eq("andi_pc", a_pc, 32'h0000_0110);

    // beq x1,x2,+8 held, then flush with an incoming illegal instruction
    drive(32'h0020_8463, 32'h0000_0200);
    tick();
    check_eq("beq_branch", {31'd0, a_branch}, 32'd1);
    check_eq("beq_alu_op", {28'd0, a_alu_op}, 32'd1);
    check_eq("beq_imm", a_imm, 32'd8);
    out_ready = 1'b0;
    flush = 1'b1;
    drive(32'hFFFF_FFFF, 32'h0000_0204);
    #1 check_eq("flush_in_ready", {31'd0, a_in_ready}, 32'd0);
    tick();
    check_eq("flush_valid", {31'd0, a_out_valid}, 32'd0);
    check_eq("flush_branch", {31'd0, a_branch}, 32'd0);
    check_eq("flush_cnt", {16'd0, a_cnt}, 32'd0);
    flush = 1'b0;
    out_ready = 1'b1;

    // Illegal instructions and counter saturation
    tick();
    check_eq("ill1_flag", {31'd0, a_illegal}, 32'd1);
    check_eq("ill1_cnt", {16'd0, a_cnt}, 32'd1);
    drive(32'h4000_4033, 32'h0000_0208);
    tick();
    check_eq("ill2_flag", {31'd0, a_illegal}, 32'd1);
    check_eq("ill2_rw", {31'd0, a_reg_write}, 32'd0);
    check_eq("ill2_cnt_a", {16'd0, a_cnt}, 32'd2);
    check_eq("ill2_cnt_b", {30'd0, b_cnt}, 32'd2);
    tick();
    tick();
    check_eq("ill4_cnt_a", {16'd0, a_cnt}, 32'd4);
    check_eq("ill4_cnt_b_sat", {30'd0, b_cnt}, 32'd3);

    // slt x1,x2,x3: legal in dut_a, illegal in dut_b
    drive(32'h0031_20B3, 32'h0000_020C);
    tick();
    check_eq("slt_a_ill", {31'd0, a_illegal}, 32'd0);
    check_eq("slt_a_alu_op", {28'd0, a_alu_op}, 32'd8);
    check_eq("slt_b_ill", {31'd0, b_illegal}, 32'd1);
    check_eq("slt_b_rw", {31'd0, b_reg_write}, 32'd0);
    check_eq("slt_b_cnt", {30'd0, b_cnt}, 32'd3);

    // addi x0,x0,1
    drive(32'h0010_0013, 32'h0000_0210);
    tick();
    check_eq("x0_rw", {31'd0, a_reg_write}, 32'd0);
    check_eq("x0_imm", a_imm, 32'd1);

    // srai x1,x1,3
    drive(32'h4030_D093, 32'h0000_0214);
    tick();
    check_eq("srai_alu_op", {28'd0, a_alu_op}, 32'd7);
    check_eq("srai_sftmd", {31'd0, a_sftmd}, 32'd1);
    check_eq("srai_imm", a_imm, 32'd3);

    // addi x1,x0,-1
    drive(32'hFFF0_0093, 32'h0000_0218);
    tick();
    check_eq("neg_imm", a_imm, 32'hFFFF_FFFF);

    // lui x5,0x12345
    drive(32'h1234_52B7, 32'h0000_021C);
    tick();
    check_eq("lui_imm", a_imm, 32'h1234_5000);
    check_eq("lui_alu_op", {28'd0, a_alu_op}, 32'd10);
    check_eq("lui_b_ill", {31'd0, b_illegal}, 32'd1);

    // jal x1,+16
    drive(32'h0100_00EF, 32'h0000_0220);
    tick();
    check_eq("jal_flag", {31'd0, a_jal}, 32'd1);
    check_eq("jal_imm", a_imm, 32'd16);

    // Reset while a bundle is held
    in_valid = 1'b0;
    out_ready = 1'b0;
    rst = 1'b1;
    tick();
    check_eq("midrst_valid", {31'd0, a_out_valid}, 32'd0);
    check_eq("midrst_cnt", {16'd0, a_cnt}, 32'd0);
    check_eq("midrst_jal", {31'd0, a_jal}, 32'd0);
    rst = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
